// File: rtl/ll_free_pool.sv
// Free-node allocator for the shared linked-list memory.
// Hands out unused node indices, takes back released ones, flags bad frees.
module ll_free_pool #(
    parameter  int MEM_D = 16,
    localparam int PTR_W = $clog2(MEM_D),
    localparam int CNT_W = $clog2(MEM_D + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_vld,
    output logic [PTR_W-1:0] alloc_ptr,
    output logic             alloc_fail,
    input  logic             free_req,
    input  logic [PTR_W-1:0] free_ptr,
    output logic             free_err,
    output logic             init_done,
    output logic [CNT_W-1:0] free_cnt,
    output logic             empty
);

    localparam logic [PTR_W:0]   MEM_W = (PTR_W + 1)'(MEM_D);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(MEM_D - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] q [MEM_D];
    logic [PTR_W-1:0] init_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [MEM_D-1:0] inuse;
    logic [CNT_W-1:0] cnt_nx;
    logic             ready;
    logic             init_last;
    logic             in_range;
    logic             grant;
    logic             accept;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign ready     = (state == S_READY);
    assign init_last = (init_cnt == LAST);
    assign in_range  = ({1'b0, free_ptr} < MEM_W);
    // Decisions use pre-cycle state only: no free-to-alloc bypass.
    assign grant     = ready && alloc_req && (free_cnt != '0);
    assign accept    = ready && free_req && in_range && inuse[free_ptr];

    // Next state: INIT walks every node once, then READY until reset.
    always_comb begin
        state_nx = state;
        if (state == S_INIT && init_last) begin
            state_nx = S_READY;
        end
    end

    // Next free count: init fills one node per cycle, then grant/accept.
    always_comb begin
        cnt_nx = free_cnt;
        if (!ready) begin
            cnt_nx = free_cnt + 1'b1;
        end else if (grant && !accept) begin
            cnt_nx = free_cnt - 1'b1;
        end else if (accept && !grant) begin
            cnt_nx = free_cnt + 1'b1;
        end
    end

    // Control state, queue pointers, in-use bitmap and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inuse      <= '0;
            alloc_vld  <= 1'b0;
            alloc_ptr  <= '0;
            alloc_fail <= 1'b0;
            free_err   <= 1'b0;
            init_done  <= 1'b0;
            free_cnt   <= '0;
            empty      <= 1'b1;
        end else begin
            state      <= state_nx;
            free_cnt   <= cnt_nx;
            init_done  <= (state_nx == S_READY);
            empty      <= (cnt_nx == '0) || (state_nx != S_READY);
            alloc_vld  <= grant;
            alloc_fail <= alloc_req && !grant;
            free_err   <= free_req && !accept;
            if (!ready) begin
                init_cnt <= init_last ? '0 : init_cnt + 1'b1;
            end
            if (grant) begin
                alloc_ptr        <= q[rd_ptr];
                rd_ptr           <= bump(rd_ptr);
                inuse[q[rd_ptr]] <= 1'b1;
            end
            if (accept) begin
                wr_ptr          <= bump(wr_ptr);
                inuse[free_ptr] <= 1'b0;
            end
        end
    end

    // Queue storage: seeded with 0..MEM_D-1 during INIT, then freed indices.
    always_ff @(posedge clk) begin
        if (!ready) begin
            q[init_cnt] <= init_cnt;
        end else if (accept) begin
            q[wr_ptr] <= free_ptr;
        end
    end

endmodule

// File: tb/tb_ll_free_pool.sv
// Directed bench for ll_free_pool: MEM_D=16 main instance,
// MEM_D=12 instance for non-power-of-two pointer wrap.
module tb_ll_free_pool;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, alloc_req, free_req;
    logic [3:0] free_ptr;
    logic       alloc_vld, alloc_fail, free_err, init_done, empty;
    logic [3:0] alloc_ptr;
    logic [4:0] free_cnt;

    logic       b_rst_n, b_alloc_req, b_free_req;
    logic [3:0] b_free_ptr;
    logic       b_alloc_vld, b_alloc_fail, b_free_err, b_init_done, b_empty;
    logic [3:0] b_alloc_ptr;
    logic [3:0] b_free_cnt;

    int n_vec = 0;
    int n_err = 0;

    ll_free_pool #(.MEM_D(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_vld(alloc_vld),
        .alloc_ptr(alloc_ptr), .alloc_fail(alloc_fail),
        .free_req(free_req), .free_ptr(free_ptr),
        .free_err(free_err), .init_done(init_done),
        .free_cnt(free_cnt), .empty(empty)
    );

    ll_free_pool #(.MEM_D(12)) dut12 (
        .clk(clk), .rst_n(b_rst_n),
        .alloc_req(b_alloc_req), .alloc_vld(b_alloc_vld),
        .alloc_ptr(b_alloc_ptr), .alloc_fail(b_alloc_fail),
        .free_req(b_free_req), .free_ptr(b_free_ptr),
        .free_err(b_free_err), .init_done(b_init_done),
        .free_cnt(b_free_cnt), .empty(b_empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; alloc_req = 1'b0; free_req = 1'b0; free_ptr = '0;
        step(); step();
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done got %0b want 0", init_done); end
        n_vec++; if (free_cnt !== 5'd0) begin n_err++; $display("FAIL rst_free_cnt got %0d want 0", free_cnt); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b want 1", empty); end
        n_vec++; if (alloc_vld !== 1'b0) begin n_err++; $display("FAIL rst_alloc_vld got %0b want 0", alloc_vld); end
        rst_n = 1'b1;
        alloc_req = 1'b1; free_req = 1'b1; free_ptr = 4'd0;
        step();
        n_vec++; if (alloc_fail !== 1'b1) begin n_err++; $display("FAIL init_alloc_fail got %0b want 1", alloc_fail); end
        n_vec++; if (alloc_vld !== 1'b0) begin n_err++; $display("FAIL init_alloc_vld got %0b want 0", alloc_vld); end
        n_vec++; if (free_err !== 1'b1) begin n_err++; $display("FAIL init_free_err got %0b want 1", free_err); end
        n_vec++; if (free_cnt !== 5'd1) begin n_err++; $display("FAIL init_cnt1 got %0d want 1", free_cnt); end
        alloc_req = 1'b0; free_req = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            step();
            if (i == 15) begin
                n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init15_done got %0b want 0", init_done); end
                n_vec++; if (free_cnt !== 5'd15) begin n_err++; $display("FAIL init15_cnt got %0d want 15", free_cnt); end
                n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL init15_empty got %0b want 1", empty); end
            end
        end
        n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init16_done got %0b want 1", init_done); end
        n_vec++; if (free_cnt !== 5'd16) begin n_err++; $display("FAIL init16_cnt got %0d want 16", free_cnt); end
        n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL init16_empty got %0b want 0", empty); end
    endtask

    task automatic test_bad_free();
        free_req = 1'b1; free_ptr = 4'd9;
        step();
        n_vec++; if (free_err !== 1'b1) begin n_err++; $display("FAIL free9_err got %0b want 1", free_err); end
        n_vec++; if (free_cnt !== 5'd16) begin n_err++; $display("FAIL free9_cnt got %0d want 16", free_cnt); end
        free_req = 1'b0;
        step();
        n_vec++; if (free_err !== 1'b0) begin n_err++; $display("FAIL free_err_pulse got %0b want 0", free_err); end
    endtask

    task automatic test_alloc_all();
        alloc_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_vec++; if (alloc_vld !== 1'b1) begin n_err++; $display("FAIL alloc%0d_vld got %0b want 1", i, alloc_vld); end
            n_vec++; if (alloc_ptr !== 4'(i)) begin n_err++; $display("FAIL alloc%0d_ptr got %0d want %0d", i, alloc_ptr, i); end
            n_vec++; if (free_cnt !== 5'(15 - i)) begin n_err++; $display("FAIL alloc%0d_cnt got %0d want %0d", i, free_cnt, 15 - i); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drained_empty got %0b want 1", empty); end
        step();
        n_vec++; if (alloc_fail !== 1'b1) begin n_err++; $display("FAIL alloc17_fail got %0b want 1", alloc_fail); end
        n_vec++; if (alloc_vld !== 1'b0) begin n_err++; $display("FAIL alloc17_vld got %0b want 0", alloc_vld); end
        n_vec++; if (free_cnt !== 5'd0) begin n_err++; $display("FAIL alloc17_cnt got %0d want 0", free_cnt); end
        alloc_req = 1'b0;
        step();
        n_vec++; if (alloc_fail !== 1'b0) begin n_err++; $display("FAIL fail_pulse got %0b want 0", alloc_fail); end
        n_vec++; if (alloc_ptr !== 4'd15) begin n_err++; $display("FAIL ptr_hold got %0d want 15", alloc_ptr); end
    endtask

    task automatic test_fifo_reuse();
        free_req = 1'b1; free_ptr = 4'd5;
        step();
        n_vec++; if (free_err !== 1'b0) begin n_err++; $display("FAIL free5_err got %0b want 0", free_err); end
        n_vec++; if (free_cnt !== 5'd1) begin n_err++; $display("FAIL free5_cnt got %0d want 1", free_cnt); end
        free_ptr = 4'd2;
        step();
        n_vec++; if (free_cnt !== 5'd2) begin n_err++; $display("FAIL free2_cnt got %0d want 2", free_cnt); end
        free_req = 1'b0; alloc_req = 1'b1;
        step();
        n_vec++; if (alloc_ptr !== 4'd5 || alloc_vld !== 1'b1) begin n_err++; $display("FAIL reuse1 got ptr %0d vld %0b want ptr 5 vld 1", alloc_ptr, alloc_vld); end
        step();
        n_vec++; if (alloc_ptr !== 4'd2 || alloc_vld !== 1'b1) begin n_err++; $display("FAIL reuse2 got ptr %0d vld %0b want ptr 2 vld 1", alloc_ptr, alloc_vld); end
        n_vec++; if (free_cnt !== 5'd0) begin n_err++; $display("FAIL reuse_cnt got %0d want 0", free_cnt); end
        alloc_req = 1'b0;
        step();
    endtask

    task automatic test_double_free();
        free_req = 1'b1; free_ptr = 4'd5;
        step();
        n_vec++; if (free_err !== 1'b0) begin n_err++; $display("FAIL dfree1_err got %0b want 0", free_err); end
        step();
        n_vec++; if (free_err !== 1'b1) begin n_err++; $display("FAIL dfree2_err got %0b want 1", free_err); end
        n_vec++; if (free_cnt !== 5'd1) begin n_err++; $display("FAIL dfree2_cnt got %0d want 1", free_cnt); end
        free_req = 1'b0;
        step();
    endtask

    task automatic test_empty_simul();
        alloc_req = 1'b1;
        step();
        n_vec++; if (alloc_ptr !== 4'd5 || free_cnt !== 5'd0) begin n_err++; $display("FAIL pre_empty got ptr %0d cnt %0d want ptr 5 cnt 0", alloc_ptr, free_cnt); end
        free_req = 1'b1; free_ptr = 4'd3;
        step();
        n_vec++; if (alloc_fail !== 1'b1 || alloc_vld !== 1'b0) begin n_err++; $display("FAIL nobypass got fail %0b vld %0b want fail 1 vld 0", alloc_fail, alloc_vld); end
        n_vec++; if (free_err !== 1'b0) begin n_err++; $display("FAIL nobypass_ferr got %0b want 0", free_err); end
        n_vec++; if (free_cnt !== 5'd1 || empty !== 1'b0) begin n_err++; $display("FAIL nobypass_cnt got cnt %0d empty %0b want cnt 1 empty 0", free_cnt, empty); end
        free_req = 1'b0;
        step();
        n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 4'd3) begin n_err++; $display("FAIL after_bypass got vld %0b ptr %0d want vld 1 ptr 3", alloc_vld, alloc_ptr); end
        alloc_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        free_req = 1'b1; free_ptr = 4'd7;
        step();
        alloc_req = 1'b1; free_ptr = 4'd0;
        step();
        n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 4'd7) begin n_err++; $display("FAIL both_alloc got vld %0b ptr %0d want vld 1 ptr 7", alloc_vld, alloc_ptr); end
        n_vec++; if (free_err !== 1'b0 || free_cnt !== 5'd1) begin n_err++; $display("FAIL both_free got err %0b cnt %0d want err 0 cnt 1", free_err, free_cnt); end
        step();
        n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 4'd0) begin n_err++; $display("FAIL same_idx_alloc got vld %0b ptr %0d want vld 1 ptr 0", alloc_vld, alloc_ptr); end
        n_vec++; if (free_err !== 1'b1 || free_cnt !== 5'd0) begin n_err++; $display("FAIL same_idx_free got err %0b cnt %0d want err 1 cnt 0", free_err, free_cnt); end
        alloc_req = 1'b0; free_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (16) step();
        alloc_req = 1'b1;
        repeat (7) step();
        n_vec++; if (alloc_ptr !== 4'd6 || free_cnt !== 5'd9) begin n_err++; $display("FAIL seven_alloc got ptr %0d cnt %0d want ptr 6 cnt 9", alloc_ptr, free_cnt); end
        alloc_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (alloc_vld !== 1'b0 || alloc_ptr !== 4'd0) begin n_err++; $display("FAIL mid_rst_alloc got vld %0b ptr %0d want vld 0 ptr 0", alloc_vld, alloc_ptr); end
        n_vec++; if (free_cnt !== 5'd0 || empty !== 1'b1 || init_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_stat got cnt %0d empty %0b done %0b want 0 1 0", free_cnt, empty, init_done); end
        step();
        rst_n = 1'b1;
        repeat (15) step();
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rerun15_done got %0b want 0", init_done); end
        step();
        n_vec++; if (init_done !== 1'b1 || free_cnt !== 5'd16) begin n_err++; $display("FAIL rerun16 got done %0b cnt %0d want 1 16", init_done, free_cnt); end
        alloc_req = 1'b1;
        step();
        n_vec++; if (alloc_vld !== 1'b1 || alloc_ptr !== 4'd0) begin n_err++; $display("FAIL restart_alloc got vld %0b ptr %0d want vld 1 ptr 0", alloc_vld, alloc_ptr); end
        alloc_req = 1'b0;
        step();
    endtask

    task automatic test_wrap12();
        b_rst_n = 1'b1;
        repeat (11) step();
        n_vec++; if (b_init_done !== 1'b0 || b_free_cnt !== 4'd11) begin n_err++; $display("FAIL m12_init11 got done %0b cnt %0d want 0 11", b_init_done, b_free_cnt); end
        step();
        n_vec++; if (b_init_done !== 1'b1 || b_free_cnt !== 4'd12) begin n_err++; $display("FAIL m12_init12 got done %0b cnt %0d want 1 12", b_init_done, b_free_cnt); end
        b_alloc_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++; if (b_alloc_ptr !== 4'(i) || b_free_cnt !== 4'(11 - i)) begin n_err++; $display("FAIL m12_alloc%0d got ptr %0d cnt %0d want %0d %0d", i, b_alloc_ptr, b_free_cnt, i, 11 - i); end
        end
        b_alloc_req = 1'b0; b_free_req = 1'b1; b_free_ptr = 4'd11;
        step();
        b_free_ptr = 4'd4;
        step();
        n_vec++; if (b_free_cnt !== 4'd2) begin n_err++; $display("FAIL m12_frees got %0d want 2", b_free_cnt); end
        b_free_req = 1'b0; b_alloc_req = 1'b1;
        step();
        n_vec++; if (b_alloc_ptr !== 4'd11) begin n_err++; $display("FAIL m12_rdwrap1 got %0d want 11", b_alloc_ptr); end
        step();
        n_vec++; if (b_alloc_ptr !== 4'd4) begin n_err++; $display("FAIL m12_rdwrap2 got %0d want 4", b_alloc_ptr); end
        b_alloc_req = 1'b0; b_free_req = 1'b1; b_free_ptr = 4'd12;
        step();
        n_vec++; if (b_free_err !== 1'b1) begin n_err++; $display("FAIL m12_oor12 got %0b want 1", b_free_err); end
        b_free_ptr = 4'd13;
        step();
        n_vec++; if (b_free_err !== 1'b1 || b_free_cnt !== 4'd0) begin n_err++; $display("FAIL m12_oor13 got err %0b cnt %0d want 1 0", b_free_err, b_free_cnt); end
        for (int i = 0; i < 12; i++) begin
            b_free_ptr = 4'(i);
            step();
            n_vec++; if (b_free_err !== 1'b0) begin n_err++; $display("FAIL m12_free%0d got err %0b want 0", i, b_free_err); end
        end
        n_vec++; if (b_free_cnt !== 4'd12) begin n_err++; $display("FAIL m12_full got %0d want 12", b_free_cnt); end
        b_free_req = 1'b0; b_alloc_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_vec++; if (b_alloc_ptr !== 4'(i)) begin n_err++; $display("FAIL m12_wralloc%0d got %0d want %0d", i, b_alloc_ptr, i); end
        end
        n_vec++; if (b_empty !== 1'b1) begin n_err++; $display("FAIL m12_empty got %0b want 1", b_empty); end
        b_alloc_req = 1'b0;
        step();
    endtask

    initial begin
        b_rst_n = 1'b0; b_alloc_req = 1'b0; b_free_req = 1'b0; b_free_ptr = '0;
        test_reset();
        test_bad_free();
        test_alloc_all();
        test_fifo_reuse();
        test_double_free();
        test_empty_simul();
        test_back_to_back();
        test_reset_mid();
        test_wrap12();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
